sd_sector_loader: RTL and testbench

- Sequencer in front of the `readsd` SD-card sector reader.
- Given a start sector and a sector count, it:
  - waits for card init,
  - issues one read request per sector,
  - counts the 512 data bytes of each sector and writes them linearly into a frame/sprite RAM,
  - advances the sector address,
  - signals done or error.
- Sits between game-level asset loading logic and the `readsd` datapath, all on `sd_clk`.

---
 rtl/sd_sector_loader_if.sv | 35 +++
 rtl/sd_sector_loader.sv | 158 +++++++++++++++
 tb/tb_sd_sector_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_loader_if.sv
// Loader-side bundle: start/config inputs, readsd request/data handshake, RAM write port, status.
// master = the sector loader, slave = the surrounding logic (reader, RAM, asset loader).
interface sd_sector_loader_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
);
  logic              init;
  logic              start;
  logic [31:0]       start_sec;
  logic [CNT_W-1:0]  sec_count;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       sec;
  logic              read_req;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              read_complete;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  init, start, start_sec, sec_count, base_addr,
    input  rd_data, rd_valid, read_complete,
    output sec, read_req, ram_we, ram_addr, ram_wdata, busy, done, error
  );

  modport slave (
    output init, start, start_sec, sec_count, base_addr,
    output rd_data, rd_valid, read_complete,
    input  sec, read_req, ram_we, ram_addr, ram_wdata, busy, done, error
  );
endinterface

// File: rtl/sd_sector_loader.sv
// Sequences multi-sector reads from the readsd reader and streams the bytes into a linear RAM image.
// Optional watchdog plus per-sector retry is built when SD_LOADER_TIMEOUT_EN is defined.
module sd_sector_loader #(
  parameter int ADDR_W    = 17,
  parameter int SEC_BYTES = 512,
  parameter int CNT_W     = 16
) (
  input logic                sd_clk,
  input logic                rst_n,
  sd_sector_loader_if.master bus
);
  localparam int BC_W = $clog2(SEC_BYTES + 1);
  localparam logic [BC_W-1:0] FULL = BC_W'(SEC_BYTES);
  localparam logic [BC_W-1:0] LAST = BC_W'(SEC_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, ISSUE, RECV, NEXT, DONE, ERR} state_t;
  state_t state, state_nx;

  logic [31:0]       cur_sec;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] cur_addr;
  logic [BC_W-1:0]   byte_cnt;
  logic              ovf;
  logic              err_q;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [7:0]        wdata_p1;

  logic accept, take_byte, drop_byte, full_after, ovf_after;
  logic sector_fail, retry_ok, wd_expired;

`ifdef SD_LOADER_TIMEOUT_EN
  logic [23:0]       wd_cnt;
  logic [1:0]        retries;
  logic [ADDR_W-1:0] sec_addr;
  assign wd_expired = (state == RECV) && !bus.rd_valid && (wd_cnt == 24'hFF_FFFF);
  assign retry_ok   = (retries < 2'd2);
`else
  assign wd_expired = 1'b0;
  assign retry_ok   = 1'b0;
`endif

  // A byte arriving together with read_complete is counted before the completeness check.
  always_comb begin
    accept      = (state == IDLE) && bus.start;
    take_byte   = (state == RECV) && bus.rd_valid && (byte_cnt < FULL);
    drop_byte   = (state == RECV) && bus.rd_valid && (byte_cnt >= FULL);
    full_after  = (byte_cnt >= FULL) || (take_byte && (byte_cnt == LAST));
    ovf_after   = ovf || drop_byte;
    sector_fail = 1'b0;
    if ((state == ISSUE) || (state == RECV))
      sector_fail = !bus.init || wd_expired ||
                    ((state == RECV) && bus.read_complete && (!full_after || ovf_after));
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.read_req = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = (bus.sec_count == '0) ? DONE : WAIT_INIT;
      end
      WAIT_INIT: begin
        bus.busy = 1'b1;
        if (bus.init) state_nx = ISSUE;
      end
      ISSUE: begin
        bus.busy     = 1'b1;
        bus.read_req = 1'b1;
        state_nx     = RECV;
      end
      RECV: begin
        bus.busy     = 1'b1;
        bus.read_req = 1'b1;
        if (bus.read_complete) state_nx = NEXT;
      end
      NEXT: begin
        bus.busy = 1'b1;
        state_nx = (remaining == CNT_W'(1)) ? DONE : ISSUE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (sector_fail) state_nx = retry_ok ? ISSUE : ERR;
  end

  // Write stage p1: one register between the accepted byte and the RAM port.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sec   <= '0;
      remaining <= '0;
      cur_addr  <= '0;
      byte_cnt  <= '0;
      ovf       <= 1'b0;
      err_q     <= 1'b0;
      we_p1     <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
`ifdef SD_LOADER_TIMEOUT_EN
      wd_cnt    <= '0;
      retries   <= '0;
      sec_addr  <= '0;
`endif
    end else begin
      we_p1 <= take_byte;
      if (take_byte) begin
        addr_p1  <= cur_addr;
        wdata_p1 <= bus.rd_data;
        cur_addr <= cur_addr + ADDR_W'(1);
        byte_cnt <= byte_cnt + BC_W'(1);
      end
      if (drop_byte) ovf <= 1'b1;
      if (accept) begin
        cur_sec   <= bus.start_sec;
        remaining <= bus.sec_count;
        cur_addr  <= bus.base_addr;
        err_q     <= 1'b0;
      end
      if (state == ISSUE) begin
        byte_cnt <= '0;
        ovf      <= 1'b0;
      end
      if (state == NEXT) begin
        remaining <= remaining - CNT_W'(1);
        cur_sec   <= cur_sec + 32'd1;
      end
      if (state_nx == ERR) err_q <= 1'b1;
`ifdef SD_LOADER_TIMEOUT_EN
      if ((state == ISSUE) || bus.rd_valid) wd_cnt <= '0;
      else if (state == RECV)               wd_cnt <= wd_cnt + 24'd1;
      if (state == ISSUE) sec_addr <= cur_addr;
      if (accept || (state == NEXT)) retries <= '0;
      // A retried sector is rewritten from its own first RAM byte.
      if (sector_fail && retry_ok) begin
        retries  <= retries + 2'd1;
        cur_addr <= sec_addr;
      end
`endif
    end
  end

  assign bus.sec       = cur_sec;
  assign bus.error     = err_q;
  assign bus.ram_we    = we_p1;
  assign bus.ram_addr  = addr_p1;
  assign bus.ram_wdata = wdata_p1;
endmodule

// File: tb/tb_sd_sector_loader.sv
// Bench for sd_sector_loader: randomized-gap reader model, RAM write monitor, table of transfers
// plus random transfers checked against a byte-stream model, and a mid-sector reset sequence.
module tb_sd_sector_loader;
  localparam int ADDR_W    = 17;
  localparam int CNT_W     = 16;
  localparam int SEC_BYTES = 512;

  logic sd_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sd_clk = ~sd_clk;

  sd_sector_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  sd_sector_loader #(.ADDR_W(ADDR_W), .SEC_BYTES(SEC_BYTES), .CNT_W(CNT_W)) dut (
    .sd_clk (sd_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] start_sec;
    int          count;
    int          base;
    int          init_delay;
    int          nbytes;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reader model: answers each request with rdr_nbytes bytes (random gaps), then read_complete.
  int unsigned salt = 0;
  int          rdr_nbytes = SEC_BYTES;
  bit          rdr_active = 1'b0;
  bit          rdr_wait_low = 1'b0;
  logic [31:0] rdr_sec;
  int          rdr_idx;
  logic [31:0] req_q[$];

  function automatic logic [7:0] byte_of(input logic [31:0] s, input int idx);
    logic [31:0] m;
    m = (s * 32'd29) ^ 32'(idx * 5) ^ salt;
    return m[7:0] ^ m[15:8];
  endfunction

  always @(negedge sd_clk) begin
    bus.rd_valid      = 1'b0;
    bus.read_complete = 1'b0;
    bus.rd_data       = 8'($urandom);
    if (!rst_n) begin
      rdr_active   = 1'b0;
      rdr_wait_low = 1'b0;
    end else if (!rdr_active) begin
      if (!bus.read_req) rdr_wait_low = 1'b0;
      else if (!rdr_wait_low) begin
        rdr_active = 1'b1;
        rdr_sec    = bus.sec;
        rdr_idx    = 0;
        req_q.push_back(bus.sec);
      end
    end else if (rdr_idx < rdr_nbytes) begin
      if ($urandom_range(3) != 0) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = byte_of(rdr_sec, rdr_idx);
        rdr_idx++;
        if (rdr_idx == rdr_nbytes && $urandom_range(1) == 1) begin
          bus.read_complete = 1'b1;
          rdr_active        = 1'b0;
          rdr_wait_low      = 1'b1;
        end
      end
    end else begin
      bus.read_complete = 1'b1;
      rdr_active        = 1'b0;
      rdr_wait_low      = 1'b1;
    end
  end

  // Output monitor, sampled 1 time unit after the active edge.
  logic [ADDR_W-1:0] wa_q[$];
  logic [7:0]        wd_q[$];
  int                gap_q[$];
  int                done_cnt = 0;
  int                req_noinit = 0;
  int                lowrun = 0;
  bit                had_req = 1'b0;

  always @(posedge sd_clk) begin
    #1;
    if (bus.ram_we) begin
      wa_q.push_back(bus.ram_addr);
      wd_q.push_back(bus.ram_wdata);
    end
    if (bus.done) done_cnt++;
    if (bus.read_req && !bus.init) req_noinit++;
    if (bus.read_req) begin
      if (had_req && lowrun > 0) gap_q.push_back(lowrun);
      lowrun  = 0;
      had_req = 1'b1;
    end else if (had_req && bus.busy) lowrun++;
  end

  task automatic clear_capture();
    wa_q.delete();
    wd_q.delete();
    req_q.delete();
    gap_q.delete();
    done_cnt   = 0;
    req_noinit = 0;
    had_req    = 1'b0;
    lowrun     = 0;
  endtask

  task automatic issue_start(input vec_t v);
    @(negedge sd_clk);
    bus.init      = (v.init_delay == 0);
    bus.start     = 1'b1;
    bus.start_sec = v.start_sec;
    bus.sec_count = CNT_W'(v.count);
    bus.base_addr = ADDR_W'(v.base);
    @(negedge sd_clk);
    bus.start     = 1'b0;
    bus.start_sec = $urandom;
    bus.sec_count = CNT_W'($urandom);
    bus.base_addr = ADDR_W'($urandom);
  endtask

  task automatic run(input vec_t v, input string tag);
    int          n;
    int          nbad;
    int          exp_reqs;
    int          exp_gaps;
    logic [31:0] s;
    clear_capture();
    rdr_nbytes = v.nbytes;
    salt       = $urandom;
    issue_start(v);
    check({tag, ".err_clr"}, bus.error, 0);
    if (v.count != 0) check({tag, ".busy_on"}, bus.busy, 1);
    n = 0;
    while (done_cnt == 0 && !bus.error && n < 3000 + v.count * 2000 + v.init_delay) begin
      n++;
      if (n == v.init_delay) bus.init = 1'b1;
      @(negedge sd_clk);
    end
    check({tag, ".finished_in_budget"}, (n < 3000 + v.count * 2000 + v.init_delay), 1);
    if (v.count == 0) check({tag, ".zero_done_latency_ok"}, (n <= 2), 1);
    bus.init = 1'b1;
    repeat (4) @(negedge sd_clk);

    exp_reqs = (v.count == 0) ? 0 : (v.exp_err ? 1 : v.count);
    exp_gaps = (!v.exp_err && v.count > 1) ? v.count - 1 : 0;
    check({tag, ".done_pulses"}, done_cnt, v.exp_done);
    check({tag, ".error"}, bus.error, v.exp_err);
    check({tag, ".busy_off"}, bus.busy, 0);
    check({tag, ".read_req_before_init"}, req_noinit, 0);
    check({tag, ".nwrites"}, wa_q.size(), v.exp_writes);
    nbad = 0;
    for (int k = 0; k < wa_q.size() && k < v.exp_writes; k++) begin
      s = v.start_sec + 32'(k / SEC_BYTES);
      if (wa_q[k] !== ADDR_W'(v.base + k) || wd_q[k] !== byte_of(s, k % SEC_BYTES)) nbad++;
    end
    check({tag, ".write_stream_bad"}, nbad, 0);
    check({tag, ".nreqs"}, req_q.size(), exp_reqs);
    nbad = 0;
    for (int i = 0; i < req_q.size(); i++)
      if (req_q[i] !== v.start_sec + 32'(i)) nbad++;
    check({tag, ".req_sec_bad"}, nbad, 0);
    check({tag, ".n_gaps"}, gap_q.size(), exp_gaps);
    nbad = 0;
    for (int i = 0; i < gap_q.size(); i++)
      if (gap_q[i] != 1) nbad++;
    check({tag, ".gap_not_one"}, nbad, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".sec"}, bus.sec, 0);
    check({tag, ".read_req"}, bus.read_req, 0);
    check({tag, ".ram_we"}, bus.ram_we, 0);
    check({tag, ".ram_addr"}, bus.ram_addr, 0);
    check({tag, ".ram_wdata"}, bus.ram_wdata, 0);
    check({tag, ".busy_done_error"}, {bus.busy, bus.done, bus.error}, 0);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    int   n;
    int   nw;
    vecs[0] = '{32'd100, 2, 0, 0, 512, 1024, 1'b1, 1'b0};
    vecs[1] = '{32'd7, 0, 55, 0, 512, 0, 1'b1, 1'b0};
    vecs[2] = '{32'd2000, 1, 300, 50, 512, 512, 1'b1, 1'b0};
    vecs[3] = '{32'd9, 1, 0, 0, 511, 511, 1'b0, 1'b1};
    vecs[4] = '{32'd12, 1, 131068, 0, 512, 512, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 2, 1000, 0, 512, 1024, 1'b1, 1'b0};
    vecs[6] = '{32'd40, 2, 77, 0, 513, 512, 1'b0, 1'b1};
    vecs[7] = '{32'd41, 3, 5, 0, 512, 1536, 1'b1, 1'b0};

    bus.init      = 1'b1;
    bus.start     = 1'b0;
    bus.start_sec = '0;
    bus.sec_count = '0;
    bus.base_addr = '0;
    repeat (3) @(negedge sd_clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sd_clk);

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 6; r++) begin
      v.start_sec  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
      v.count      = $urandom_range(3);
      v.base       = int'($urandom_range((1 << ADDR_W) - 1));
      v.init_delay = ($urandom_range(3) == 0) ? int'($urandom_range(40, 5)) : 0;
      v.nbytes     = SEC_BYTES;
      if ($urandom_range(5) == 0)
        v.nbytes = ($urandom_range(1) == 1) ? SEC_BYTES + 1 : SEC_BYTES - 1 - int'($urandom_range(20));
      v.exp_err    = (v.count > 0) && (v.nbytes != SEC_BYTES);
      v.exp_done   = !v.exp_err;
      v.exp_writes = (v.count == 0) ? 0 :
                     v.exp_err ? ((v.nbytes < SEC_BYTES) ? v.nbytes : SEC_BYTES) :
                     v.count * SEC_BYTES;
      run(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a sector, then a clean restart at a new sector.
    clear_capture();
    rdr_nbytes = SEC_BYTES;
    salt       = $urandom;
    v = '{32'd500, 2, 0, 0, 512, 0, 1'b0, 1'b0};
    issue_start(v);
    n = 0;
    while (wa_q.size() < 200 && n < 5000) begin
      n++;
      @(negedge sd_clk);
    end
    check("midrst.reached_200_bytes", (wa_q.size() >= 200), 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    nw = wa_q.size();
    repeat (5) @(negedge sd_clk);
    check("midrst.writes_in_reset", wa_q.size(), nw);
    rst_n = 1'b1;
    run('{32'd900, 1, 50, 0, 512, 512, 1'b1, 1'b0}, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
